// File: rtl/lsd_readout_sequencer.sv
// LSD line-segment buffer readout sequencer.
// Walks the buffer's combinational read port from address 0 to line count - 1 and
// streams each segment word on a valid/ready master with a last marker. Readout is
// dropped (sticky error) if the buffer's ready flag falls mid-stream.
module lsd_readout_sequencer #(
    parameter int FRAME_HEIGHT = -1,
    parameter int FRAME_WIDTH  = -1,
    parameter int RAM_SIZE     = 4096,
    localparam int V_BITW      = (FRAME_HEIGHT > 1) ? $clog2(FRAME_HEIGHT) : 1,
    localparam int H_BITW      = (FRAME_WIDTH > 1) ? $clog2(FRAME_WIDTH) : 1,
    localparam int ADDR_BITW   = (RAM_SIZE > 1) ? $clog2(RAM_SIZE) : 1,
    localparam int WORD_SIZE   = (H_BITW + V_BITW) * 2
) (
    input  logic                 clock,
    input  logic                 n_rst,
    input  logic                 in_ready,
    input  logic [ADDR_BITW:0]   in_line_num,
    input  logic [WORD_SIZE-1:0] in_data,
    output logic [ADDR_BITW-1:0] out_rd_addr,
    input  logic                 in_start,
    input  logic                 in_abort,
    output logic                 m_valid,
    input  logic                 m_ready,
    output logic [WORD_SIZE-1:0] m_data,
    output logic                 m_last,
    output logic                 out_busy,
    output logic                 out_done,
    output logic                 out_error,
    output logic [ADDR_BITW:0]   out_count
);

    localparam int CNT_W = ADDR_BITW + 1;

    typedef enum logic {StIdle, StStream} state_e;

    state_e               state_q, state_d;
    logic [CNT_W-1:0]     total_q, total_d;
    logic [CNT_W-1:0]     idx_q, idx_d;
    logic [CNT_W-1:0]     count_q, count_d;
    logic [WORD_SIZE-1:0] data_q, data_d;
    logic                 valid_q, valid_d;
    logic                 last_q, last_d;
    logic                 done_q, done_d;
    logic                 error_q, error_d;

    logic accept, handshake, load, complete, kill;

    assign accept    = in_start && in_ready && (in_line_num != '0);
    assign handshake = valid_q && m_ready;
    assign load      = (!valid_q || m_ready) && (idx_q < total_q);
    // A completing last handshake wins over abort / buffer loss in the same cycle.
    assign complete  = handshake && last_q;
    assign kill      = in_abort || !in_ready;

    // State register
    always_ff @(posedge clock or negedge n_rst) begin
        if (!n_rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decode
    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:   if (accept) state_d = StStream;
            StStream: if (complete || kill) state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    // Datapath next-state: fetch, handshake counting, completion, abort/loss
    always_comb begin
        total_d = total_q;
        idx_d   = idx_q;
        count_d = count_q;
        data_d  = data_q;
        valid_d = valid_q;
        last_d  = last_q;
        done_d  = 1'b0;
        error_d = error_q;
        if (state_q == StIdle) begin
            if (accept) begin
                total_d = in_line_num;
                idx_d   = '0;
                count_d = '0;
                error_d = 1'b0;
            end
        end else begin
            if (handshake) count_d = count_q + CNT_W'(1);
            if (complete) begin
                done_d  = 1'b1;
                idx_d   = '0;
                valid_d = 1'b0;
                last_d  = 1'b0;
            end else if (kill) begin
                valid_d = 1'b0;
                last_d  = 1'b0;
                if (!in_ready) error_d = 1'b1;
            end else if (load) begin
                data_d  = in_data;
                valid_d = 1'b1;
                last_d  = (idx_q == total_q - CNT_W'(1));
                idx_d   = idx_q + CNT_W'(1);
            end else if (handshake) begin
                valid_d = 1'b0;
                last_d  = 1'b0;
            end
        end
    end

    // Datapath registers
    always_ff @(posedge clock or negedge n_rst) begin
        if (!n_rst) begin
            total_q <= '0;
            idx_q   <= '0;
            count_q <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            done_q  <= 1'b0;
            error_q <= 1'b0;
        end else begin
            total_q <= total_d;
            idx_q   <= idx_d;
            count_q <= count_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            last_q  <= last_d;
            done_q  <= done_d;
            error_q <= error_d;
        end
    end

    // Output decode
    always_comb begin
        out_busy    = (state_q == StStream);
        out_rd_addr = idx_q[ADDR_BITW-1:0];
        m_valid     = valid_q;
        m_data      = data_q;
        m_last      = last_q;
        out_done    = done_q;
        out_error   = error_q;
        out_count   = count_q;
    end

endmodule

// File: tb/tb_lsd_readout_sequencer.sv
// Randomized self-checking bench for lsd_readout_sequencer against a behavioural model.
module tb_lsd_readout_sequencer;

    localparam int FH = 16;
    localparam int FW = 16;
    localparam int RS = 16;
    localparam int AW = 4;
    localparam int WS = 16;

    logic          clock = 1'b0;
    logic          n_rst;
    logic          in_ready;
    logic [AW:0]   in_line_num;
    logic [WS-1:0] in_data;
    logic [AW-1:0] out_rd_addr;
    logic          in_start;
    logic          in_abort;
    logic          m_valid;
    logic          m_ready;
    logic [WS-1:0] m_data;
    logic          m_last;
    logic          out_busy;
    logic          out_done;
    logic          out_error;
    logic [AW:0]   out_count;

    logic [WS-1:0] mem [RS];

    int n_checks = 0;
    int n_pass   = 0;

    // behavioural model state
    bit            mbusy;
    int            mtot, midx, mcount;
    bit            mvalid, mlast, mdone, merr;
    logic [WS-1:0] mdata;
    int            seq_n;

    always #5 clock = ~clock;

    assign in_data = mem[out_rd_addr];

    lsd_readout_sequencer #(
        .FRAME_HEIGHT(FH),
        .FRAME_WIDTH (FW),
        .RAM_SIZE    (RS)
    ) dut (
        .clock      (clock),
        .n_rst      (n_rst),
        .in_ready   (in_ready),
        .in_line_num(in_line_num),
        .in_data    (in_data),
        .out_rd_addr(out_rd_addr),
        .in_start   (in_start),
        .in_abort   (in_abort),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_data     (m_data),
        .m_last     (m_last),
        .out_busy   (out_busy),
        .out_done   (out_done),
        .out_error  (out_error),
        .out_count  (out_count)
    );

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    endtask

    task automatic fill_mem();
        for (int i = 0; i < RS; i++) mem[i] = WS'($urandom);
    endtask

    task automatic model_reset();
        mbusy = 0; mtot = 0; midx = 0; mcount = 0;
        mvalid = 0; mlast = 0; mdone = 0; merr = 0; mdata = '0; seq_n = 0;
    endtask

    // One clock edge of the readout rules, applied to the inputs held before the edge.
    task automatic model_step();
        bit hs;
        bit done_next;
        done_next = 0;
        if (!mbusy) begin
            if (in_start && in_ready && in_line_num != 0) begin
                mbusy = 1; mtot = int'(in_line_num); midx = 0; mcount = 0; merr = 0;
                seq_n = 0;
            end
        end else begin
            hs = mvalid && m_ready;
            if (hs) mcount++;
            if (hs && mlast) begin
                mbusy = 0; done_next = 1; midx = 0; mvalid = 0; mlast = 0;
            end else if (in_abort || !in_ready) begin
                mbusy = 0; mvalid = 0; mlast = 0;
                if (!in_ready) merr = 1;
            end else if ((!mvalid || m_ready) && midx < mtot) begin
                mdata = mem[midx]; mvalid = 1; mlast = (midx == mtot - 1); midx++;
            end else if (hs) begin
                mvalid = 0; mlast = 0;
            end
        end
        mdone = done_next;
    endtask

    task automatic compare();
        check_eq("m_valid", 32'(m_valid), 32'(mvalid));
        check_eq("m_last", 32'(m_last), 32'(mlast));
        check_eq("m_data", 32'(m_data), 32'(mdata));
        check_eq("out_busy", 32'(out_busy), 32'(mbusy));
        check_eq("out_done", 32'(out_done), 32'(mdone));
        check_eq("out_error", 32'(out_error), 32'(merr));
        check_eq("out_count", 32'(out_count), 32'(mcount));
        check_eq("out_rd_addr", 32'(out_rd_addr), 32'(midx % RS));
    endtask

    // Inputs are set before the call (at the falling edge); the stream word is
    // checked against the buffer sequence whenever a handshake is about to occur.
    task automatic cycle();
        if (m_valid && m_ready) begin
            check_eq("stream_word", 32'(m_data), 32'(mem[seq_n % RS]));
            seq_n++;
        end
        @(posedge clock);
        model_step();
        @(negedge clock);
        compare();
    endtask

    initial begin
        n_rst = 1'b0; in_ready = 1'b1; in_line_num = '0; in_start = 1'b0;
        in_abort = 1'b0; m_ready = 1'b0;
        fill_mem();
        model_reset();
        repeat (2) @(negedge clock);
        compare();
        n_rst = 1'b1;

        // basic readout, 5 words
        m_ready = 1'b1; in_line_num = 5; in_start = 1'b1;
        cycle();
        in_start = 1'b0;
        repeat (8) cycle();
        check_eq("basic_count", 32'(out_count), 32'd5);

        // backpressure, 4 words
        fill_mem();
        in_line_num = 4; in_start = 1'b1;
        cycle();
        in_start = 1'b0;
        for (int i = 0; i < 15; i++) begin
            m_ready = (i % 3 == 0);
            cycle();
        end
        check_eq("bp_count", 32'(out_count), 32'd4);

        // single word
        m_ready = 1'b1; in_line_num = 1; in_start = 1'b1;
        cycle();
        in_start = 1'b0;
        cycle();
        check_eq("single_last", 32'(m_last), 32'd1);
        cycle();
        check_eq("single_done", 32'(out_done), 32'd1);
        check_eq("single_addr", 32'(out_rd_addr), 32'd0);

        // buffer loss after 3 handshakes
        fill_mem();
        in_line_num = 8; in_start = 1'b1;
        cycle();
        in_start = 1'b0;
        for (int i = 0; i < 20 && out_busy; i++) begin
            if (seq_n == 3) begin
                m_ready = 1'b0; in_ready = 1'b0;
            end
            cycle();
        end
        check_eq("loss_err", 32'(out_error), 32'd1);
        check_eq("loss_cnt", 32'(out_count), 32'd3);
        check_eq("loss_valid", 32'(m_valid), 32'd0);
        in_ready = 1'b1; m_ready = 1'b1; in_line_num = 2; in_start = 1'b1;
        cycle();
        in_start = 1'b0;
        check_eq("restart_clr_err", 32'(out_error), 32'd0);
        repeat (4) cycle();

        // abort and buffer loss colliding with the last handshake
        for (int k = 0; k < 2; k++) begin
            in_line_num = 3; in_start = 1'b1;
            cycle();
            in_start = 1'b0;
            for (int i = 0; i < 10 && !m_last; i++) cycle();
            if (k == 0) in_abort = 1'b1;
            else in_ready = 1'b0;
            cycle();
            in_abort = 1'b0; in_ready = 1'b1;
            check_eq("coll_done", 32'(out_done), 32'd1);
            check_eq("coll_err", 32'(out_error), 32'd0);
        end

        // ignored requests
        in_ready = 1'b0; in_line_num = 5; in_start = 1'b1;
        cycle();
        check_eq("ign_not_ready", 32'(out_busy), 32'd0);
        in_ready = 1'b1; in_line_num = 0;
        cycle();
        check_eq("ign_zero_lines", 32'(out_busy), 32'd0);
        in_line_num = 4;
        repeat (10) cycle();
        in_start = 1'b0;
        repeat (8) cycle();

        // asynchronous reset mid-readout
        in_line_num = 8; in_start = 1'b1;
        cycle();
        in_start = 1'b0;
        repeat (2) cycle();
        #2 n_rst = 1'b0;
        #1;
        check_eq("rst_valid", 32'(m_valid), 32'd0);
        check_eq("rst_busy", 32'(out_busy), 32'd0);
        check_eq("rst_count", 32'(out_count), 32'd0);
        check_eq("rst_data", 32'(m_data), 32'd0);
        check_eq("rst_addr", 32'(out_rd_addr), 32'd0);
        check_eq("rst_done", 32'(out_done | out_error | m_last), 32'd0);
        model_reset();
        @(negedge clock);
        n_rst = 1'b1;

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            in_start    = ($urandom % 4) == 0;
            in_abort    = ($urandom % 40) == 0;
            in_ready    = ($urandom % 40) != 0;
            m_ready     = ($urandom % 4) != 0;
            in_line_num = (AW + 1)'($urandom % (RS + 1));
            if (!mbusy && !in_start && ($urandom % 8) == 0) fill_mem();
            cycle();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
